// File: rtl/led_pkg.sv
// led_pkg: owner/state encodings and default timing for the LED scheduler
package led_pkg;
    localparam logic [1:0] OWN_HB  = 2'd0;
    localparam logic [1:0] OWN_ACT = 2'd1;
    localparam logic [1:0] OWN_ERR = 2'd2;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FLASH_ON  = 3'd1;
    localparam logic [2:0] FLASH_OFF = 3'd2;
    localparam logic [2:0] CODE_ON   = 3'd3;
    localparam logic [2:0] CODE_OFF  = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    localparam int DEF_MS_DIV      = 50000;
    localparam int DEF_HB_HALF_MS  = 500;
    localparam int DEF_FLASH_MS    = 50;
    localparam int DEF_CODE_ON_MS  = 200;
    localparam int DEF_CODE_OFF_MS = 200;
    localparam int DEF_CODE_GAP_MS = 1000;

    function automatic logic [1:0] state_owner(input logic [2:0] s);
        return (s == IDLE) ? OWN_HB : (s == FLASH_ON || s == FLASH_OFF) ? OWN_ACT : OWN_ERR;
    endfunction
endpackage

// File: rtl/led_scheduler_if.sv
// led_scheduler_if: request/status bundle between core logic and the LED scheduler
interface led_scheduler_if;
    logic       act_req;
    logic       err_valid;
    logic [3:0] err_code;
    logic       led;
    logic [1:0] owner;
    logic       err_ack;

    modport master (output act_req, err_valid, err_code, input led, owner, err_ack);
    modport slave (input act_req, err_valid, err_code, output led, owner, err_ack);
endinterface

// File: rtl/led_ms_tick.sv
// led_ms_tick: free-running prescaler, one-cycle tick every MS_DIV clocks
module led_ms_tick #(
    parameter int MS_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(MS_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == LAST;
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_scheduler.sv
// led_scheduler: shares the status LED between heartbeat, activity flash and error blink code
// (priority error > activity > heartbeat); all phase timing counts millisecond ticks.
module led_scheduler
    import led_pkg::*;
#(
    parameter int MS_DIV      = DEF_MS_DIV,
    parameter int HB_HALF_MS  = DEF_HB_HALF_MS,
    parameter int FLASH_MS    = DEF_FLASH_MS,
    parameter int CODE_ON_MS  = DEF_CODE_ON_MS,
    parameter int CODE_OFF_MS = DEF_CODE_OFF_MS,
    parameter int CODE_GAP_MS = DEF_CODE_GAP_MS
) (
    input logic            clk,
    input logic            rst,
    led_scheduler_if.slave bus
);
    localparam logic [9:0] HB_LAST    = 10'(HB_HALF_MS - 1);
    localparam logic [9:0] FLASH_LAST = 10'(FLASH_MS - 1);
    localparam logic [9:0] ON_LAST    = 10'(CODE_ON_MS - 1);
    localparam logic [9:0] OFF_LAST   = 10'(CODE_OFF_MS - 1);
    localparam logic [9:0] GAP_LAST   = 10'(CODE_GAP_MS - 1);

    logic       tick, hb_end, ph_end, err_start;
    logic [9:0] ph_last;
    logic [9:0] hb_cnt_q, hb_cnt_d, ph_q, ph_d;
    logic [3:0] rem_q, rem_d;
    logic [2:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       hb_led_q, hb_led_d, pend_q, pend_d, led_q, led_d, err_ack_q, err_ack_d;

    led_ms_tick #(.MS_DIV(MS_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    always_comb begin
        hb_end   = tick && hb_cnt_q == HB_LAST;
        hb_cnt_d = hb_end ? '0 : tick ? hb_cnt_q + 10'd1 : hb_cnt_q;
        hb_led_d = hb_led_q ^ hb_end;
    end

    always_comb begin
        ph_last   = (state_q == FLASH_ON || state_q == FLASH_OFF) ? FLASH_LAST :
                    (state_q == CODE_ON) ? ON_LAST : (state_q == CODE_OFF) ? OFF_LAST : GAP_LAST;
        ph_end    = tick && ph_q == ph_last;
        err_start = bus.err_valid && bus.err_code != 4'd0;
        state_d   = state_q;
        rem_d     = rem_q;
        err_ack_d = 1'b0;
        // Requests accumulate only where a later flash can still honour them
        pend_d    = (state_q == IDLE || state_q == FLASH_OFF) ? pend_q | bus.act_req : pend_q;
        if (err_start && (state_q == IDLE || state_q == FLASH_ON || state_q == FLASH_OFF)) begin
            state_d = CODE_ON;
            rem_d   = bus.err_code;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = pend_q ? FLASH_ON : IDLE;
                    pend_d  = pend_q ? 1'b0 : pend_d;
                end
                FLASH_ON:  state_d = ph_end ? FLASH_OFF : FLASH_ON;
                FLASH_OFF: if (ph_end) begin
                    state_d = pend_q ? FLASH_ON : IDLE;
                    pend_d  = pend_q ? 1'b0 : bus.act_req;
                end
                CODE_ON: if (ph_end) begin
                    state_d = CODE_OFF;
                    rem_d   = rem_q - 4'd1;
                end
                CODE_OFF:  state_d = ph_end ? ((rem_q != 4'd0) ? CODE_ON : GAP) : CODE_OFF;
                GAP: if (ph_end) begin
                    state_d   = IDLE;
                    err_ack_d = 1'b1;
                end
                default:   state_d = IDLE;
            endcase
        end
        // Every transition changes state, so a state change restarts the phase timer
        ph_d    = (state_d != state_q || state_q == IDLE) ? '0 : tick ? ph_q + 10'd1 : ph_q;
        owner_d = state_owner(state_q);
        led_d   = (state_q == IDLE) ? hb_led_q : (state_q == FLASH_ON || state_q == CODE_ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            rem_q     <= '0;
            pend_q    <= 1'b0;
            hb_cnt_q  <= '0;
            hb_led_q  <= 1'b1;
            led_q     <= 1'b1;
            owner_q   <= OWN_HB;
            err_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            rem_q     <= rem_d;
            pend_q    <= pend_d;
            hb_cnt_q  <= hb_cnt_d;
            hb_led_q  <= hb_led_d;
            led_q     <= led_d;
            owner_q   <= owner_d;
            err_ack_q <= err_ack_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.owner   = owner_q;
    assign bus.err_ack = err_ack_q;
endmodule

// File: doc/led_scheduler.md
# led_scheduler

Owns the board status LED and shares it between three requesters: a free-running heartbeat, a one-shot activity flash and a repeating error blink code. It sits between the core logic and the LED/monitor pins, replacing the direct divide-and-toggle of the LED. A millisecond tick prescaler keeps every timer narrow enough for a small CPLD.

## Interface
- `MS_DIV`, 50000, clk cycles per 1 ms tick (50 MHz board clock)
- `HB_HALF_MS`, 500, heartbeat half-period in ticks
- `FLASH_MS`, 50, activity flash on-time and mandatory off-time in ticks
- `CODE_ON_MS`, 200, error blink on-time in ticks
- `CODE_OFF_MS`, 200, error blink off-time in ticks
- `CODE_GAP_MS`, 1000, dark gap after a full error code in ticks
- `clk`  in  1  board clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `act_req`  in  1  activity request; a 1-cycle pulse is sufficient
- `err_valid`  in  1  level; an error code is present
- `err_code`  in  4  blink count 1..15; 0 means no error
- `led`  out  1  registered LED drive, also routed to the monitor pin
- `owner`  out  2  current LED owner: 0 heartbeat, 1 activity, 2 error
- `err_ack`  out  1  1-cycle pulse when a full code sequence (blinks plus gap) completes

## Operation
- **Prescaler:** count 0..MS_DIV-1, wraps. `tick` is high for 1 cycle when count == MS_DIV-1, so the period is exactly MS_DIV cycles.
- **Heartbeat:** always runs, including while not the owner. `hb_led` toggles on every HB_HALF_MS-th tick. It resets to 1.
- **Activity:** `act_req` sets `pend`. From IDLE (owner 0) with `pend` set, the block enters FLASH_ON, clears `pend` and drives led=1 for FLASH_MS ticks. It then enters FLASH_OFF with led=0 for FLASH_MS ticks, then returns to IDLE.
  - A request during FLASH_ON is merged and dropped.
  - A request during FLASH_OFF stays pending and starts the next flash directly.
- **Error FSM states:** IDLE, CODE_ON, CODE_OFF, GAP.
  - From IDLE (or from either FLASH state, preempting it) with err_valid=1 and err_code≠0: latch `rem` = err_code and enter CODE_ON.
  - CODE_ON: led=1 for CODE_ON_MS ticks, then enter CODE_OFF and decrement `rem`.
  - CODE_OFF: led=0 for CODE_OFF_MS ticks. Then go to CODE_ON if `rem`≠0, else GAP.
  - GAP: led=0 for CODE_GAP_MS ticks, then pulse `err_ack` and return to IDLE. If err_valid is still 1, the code is re-latched on the next cycle.
- **Priority:** error > activity > heartbeat.
  - Preemption of a flash also clears `pend`.
  - `act_req` is ignored while owner = 2.
- **Mid-sequence changes:** a change of err_code, or deassertion of err_valid, has no effect until the current sequence returns to IDLE. A sequence always completes and is always acked.
- **Owner mapping:** IDLE→0, FLASH_*→1, CODE_*/GAP→2. `led` = `hb_led` when owner = 0.

## Timing
- **Reset values:** led=1, owner=0, err_ack=0, state IDLE, pend=0, hb_led=1, prescaler=0, all ms counters=0.
- **Output latency:** `led` and `owner` are registered, 1 cycle after the state/`hb_led` change that causes them.
- **Phase duration:** a phase entered on cycle c ends on the N-th tick strictly after c. Its length is therefore (N-1)·MS_DIV+1 to N·MS_DIV cycles.
- **Same-cycle events:**
  - A phase's end tick and a transition condition on the same cycle: the FSM takes the transition.
  - `act_req` and err_valid rising on the same cycle in IDLE: error wins and the request is dropped.
- **Widths:**
  - Phase counter is 10 bits; HB counter is 10 bits; parameters must be ≤1023 and ≥1.
  - Prescaler is $clog2(MS_DIV) bits.
  - `rem` is 4 bits.
- **Reset mid-sequence:** returns to the reset values on the next edge with no `err_ack`.

## Structure
- Shared package/header `led_pkg` holds:
  - owner encodings (OWN_HB, OWN_ACT, OWN_ERR);
  - FSM state encodings (IDLE, FLASH_ON, FLASH_OFF, CODE_ON, CODE_OFF, GAP);
  - default timing constants.
- One sub-module, `led_ms_tick` (params MS_DIV; ports clk, rst, tick). Everything else stays in `led_scheduler`.

## Test plan
Bench parameters: MS_DIV=4, HB_HALF_MS=5, FLASH_MS=2, CODE_ON_MS=2, CODE_OFF_MS=1, CODE_GAP_MS=3.
- **Reset / heartbeat:** rst high for 3 cycles, then idle 100 cycles → led=1 for the first 20 cycles after reset, then toggles every 20 cycles; owner=0 and err_ack=0 throughout.
- **Single flash:** one `act_req` pulse in IDLE → owner=1 with led=1 for 5–8 cycles, then led=0 for 5–8 cycles, then owner=0 and led follows heartbeat.
- **Back-to-back flashes:** pulse during FLASH_ON → exactly one flash. Pulse during FLASH_OFF → a second flash starts directly after the off phase.
- **Error code 3:** err_code=3 with err_valid held → 3 on-pulses, then a 9–12-cycle dark gap, one `err_ack` pulse, and the sequence repeats.
- **Mid-sequence changes:** change err_code to 5 during the second blink → still 3 blinks, the next sequence has 5. Drop err_valid mid-sequence → sequence completes, `err_ack` pulses, owner=0.
- **Preemption and reset:** err_valid during FLASH_ON → owner=2 one cycle later and the pending flash is discarded. Assert rst during GAP → next cycle led=1, owner=0, no `err_ack`.
